// File: rtl/pipo_rr_arbiter.sv
// Round-robin arbiter loading one shared parallel-in/parallel-out register.
// Define ARB_HOLD_EN to add a HOLD_CYCLES post-load hold state.
module pipo_rr_arbiter #(
  parameter  int N_REQ       = 4,
  parameter  int WIDTH       = 4,
  parameter  int HOLD_CYCLES = 2,
  localparam int IW          = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  output logic [N_REQ-1:0]       grant,
  output logic [WIDTH-1:0]       data_out,
  output logic [IW-1:0]          owner,
  output logic                   busy
);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n
    $error("N_REQ must be 2..8");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("HOLD_CYCLES must be 1..15");
  end

`ifdef ARB_HOLD_EN
  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    HOLD
  } state_t;

  logic [3:0] cnt;
`else
  typedef enum logic [1:0] {
    IDLE,
    GRANT
  } state_t;
`endif

  state_t        state;
  logic [IW-1:0] ptr;
  logic          found;
  logic [IW-1:0] win;
  logic [IW:0]   idx;

  // Search upward from ptr+1, wrapping, so the last winner is tried last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(N_REQ))
        idx = idx - (IW+1)'(N_REQ);
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      data_out <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      ptr      <= IW'(N_REQ - 1);
`ifdef ARB_HOLD_EN
      cnt      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant    <= N_REQ'(1) << win;
            data_out <= data_in[int'(win)*WIDTH +: WIDTH];
            owner    <= win;
            ptr      <= win;
            busy     <= 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          grant <= '0;
`ifdef ARB_HOLD_EN
          cnt   <= 4'(HOLD_CYCLES);
          state <= HOLD;
`else
          busy  <= 1'b0;
          state <= IDLE;
`endif
        end
`ifdef ARB_HOLD_EN
        HOLD: begin
          if (cnt <= 4'd1) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
`endif
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipo_rr_arbiter.sv
// Scoreboard bench for pipo_rr_arbiter: directed requests, queued grants.
// Expected grant timing follows ARB_HOLD_EN with HOLD_CYCLES=2.
module tb_pipo_rr_arbiter;

  localparam int N = 4;
  localparam int W = 4;
`ifdef ARB_HOLD_EN
  localparam int HOLD_ON = 1;
`else
  localparam int HOLD_ON = 0;
`endif
  localparam int SP = HOLD_ON ? 4 : 2;

  typedef struct {
    int g;
    int d;
    int o;
    int c;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N*W-1:0] data_in;
  logic [N-1:0] grant;
  logic [W-1:0] data_out;
  logic [1:0]   owner;
  logic         busy;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   prev_g = 1'b0;
  exp_t sb[$];

  pipo_rr_arbiter #(
    .N_REQ(N),
    .WIDTH(W),
    .HOLD_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .data_in(data_in),
    .grant(grant),
    .data_out(data_out),
    .owner(owner),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic push(input int g, input int d, input int o, input int c);
    exp_t e;
    e.g = g;
    e.d = d;
    e.o = o;
    e.c = c;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    chk("idle_timeout", int'(ok), 1);
  endtask

  // Monitor: pops one expectation for each grant pulse seen.
  always @(negedge clk) begin
    exp_t e;
    if (prev_g) begin
      chk("post_grant_zero", int'(grant), 0);
      chk("post_grant_busy", int'(busy), HOLD_ON);
    end
    if (grant != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_grant", int'(grant), 0);
      end else begin
        e = sb.pop_front();
        chk("grant", int'(grant), e.g);
        chk("data_out", int'(data_out), e.d);
        chk("owner", int'(owner), e.o);
        chk("busy", int'(busy), 1);
        chk("grant_cycle", cyc, e.c);
      end
    end
    prev_g = (grant != '0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    req     = '0;
    data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", int'(grant), 0);
    chk("rst_data", int'(data_out), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single request from requester 2
    @(posedge clk);
    #1;
    data_in[8 +: 4] = 4'hA;
    req = 4'b0100;
    push(4, 10, 2, cyc + 1);
    @(posedge clk);
    #1;
    req = '0;
    data_in[8 +: 4] = 4'h5;
    @(negedge clk);
    repeat (2) begin
      @(negedge clk);
      chk("hold_data", int'(data_out), 10);
      chk("hold_owner", int'(owner), 2);
    end
    wait_idle();

    // Re-grant same requester picks up new data
    @(posedge clk);
    #1 req = 4'b0100;
    push(4, 5, 2, cyc + 1);
    @(posedge clk);
    #1 req = '0;
    wait_idle();

    // Rotation under all-ones request from fresh reset
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    data_in = 16'h4321;
    req = 4'b1111;
    for (int k = 0; k < 5; k++)
      push(1 << (k % 4), (k % 4) + 1, k % 4, cyc + 1 + k * SP);
    repeat (1 + 4 * SP) @(posedge clk);
    #1 req = '0;
    wait_idle();

    // Reset aborts an operation in progress
    @(posedge clk);
    #1 req = 4'b1000;
    push(8, 4, 3, cyc + 1);
    @(posedge clk);
    #1 req = '0;
`ifdef ARB_HOLD_EN
    @(posedge clk);
    #1;
`endif
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    req = 4'b0010;
    push(2, 2, 1, cyc + 1);
    @(negedge clk);
    chk("abort_data", int'(data_out), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_grant", int'(grant), 0);
    chk("abort_owner", int'(owner), 0);
    @(posedge clk);
    #1 req = '0;
    wait_idle();

    // Pointer wrap from owner 3 back to requester 0
    @(posedge clk);
    #1 req = 4'b1000;
    push(8, 4, 3, cyc + 1);
    @(posedge clk);
    #1 req = '0;
    wait_idle();
    chk("wrap_owner", int'(owner), 3);
    @(posedge clk);
    #1 req = 4'b1001;
    push(1, 1, 0, cyc + 1);
    push(8, 4, 3, cyc + 1 + SP);
    repeat (1 + SP) @(posedge clk);
    #1 req = '0;
    wait_idle();

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
